apb_req_bridge: RTL and testbench

APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

---
 rtl/apb_req_bridge.sv | 125 ++++++++++++
 tb/tb_apb_req_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_bridge.sv
// Single-outstanding request/response to APB master bridge; optional ACCESS timeout via APB_REQ_BRIDGE_TIMEOUT_EN.
// Latency: accept edge N -> SETUP, ACCESS, rsp_valid in the third cycle after accept plus one per wait state.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready, blocking new requests.
module apb_req_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WSTRB_WIDTH    = (DATA_WIDTH - 1) / 8 + 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [WSTRB_WIDTH-1:0] req_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic                   m_psel,
    output logic                   m_penable,
    output logic                   m_pwrite,
    output logic [ADDR_WIDTH-1:0]  m_paddr,
    output logic [DATA_WIDTH-1:0]  m_pwdata,
    output logic [WSTRB_WIDTH-1:0] m_pstrb,
    input  logic [DATA_WIDTH-1:0]  m_prdata,
    input  logic                   m_pready,
    input  logic                   m_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   tmo;

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Fires on the last permitted wait cycle, so ACCESS lasts exactly TIMEOUT_CYCLES cycles.
    assign tmo = (state == ACCESS) && !m_pready &&
                 (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !m_pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        m_psel    = 1'b0;
        m_penable = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SETUP;
            end
            SETUP: begin
                m_psel    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
                if (m_pready || tmo) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are only loaded in IDLE, so they stay stable for the whole APB transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                m_pwrite <= req_write;
                m_paddr  <= req_addr;
                m_pwdata <= req_wdata;
                m_pstrb  <= req_write ? req_strb : '0;
            end
            if (state == ACCESS) begin
                // Slave completion takes priority over a coincident timeout.
                if (m_pready) begin
                    rsp_rdata <= m_pwrite ? '0 : m_prdata;
                    rsp_err   <= m_pslverr;
                end else if (tmo) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboard bench for apb_req_bridge: expected responses queued at issue, popped on rsp_valid.
module tb_apb_req_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic [SW-1:0] m_pstrb;
    logic [DW-1:0] m_prdata = '0;
    logic          m_pready = 1'b0;
    logic          m_pslverr = 1'b0;

    apb_req_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WSTRB_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one request and returns in the SETUP cycle (just after a negedge).
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = ~strb;
    endtask

    // Waits (bounded) for rsp_valid, checks it against the scoreboard head, holds it, then handshakes.
    task automatic get_rsp(input int hold, output int waited);
        exp_t e;
        waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_valid", rsp_valid, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_req_ready", req_ready, 0);
            check("hold_rsp_valid", rsp_valid, 1);
            m_pready  = 1'b1;
            m_pslverr = ~e.err;
            m_prdata  = ~e.rdata;
            @(negedge clk);
        end
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("resp_psel", {m_psel, m_penable}, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("back_idle_ready", req_ready, 1);
    endtask

    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input int waits, input logic slverr,
                           input logic [DW-1:0] prdata, input int hold);
        exp_t e;
        int   lat;
        int   w;
        e.err   = slverr;
        e.rdata = wr ? '0 : prdata;
        exp_q.push_back(e);
        issue(wr, addr, wdata, strb);
        lat = 1;
        check("setup_psel", m_psel, 1);
        check("setup_penable", m_penable, 0);
        check("setup_paddr", m_paddr, addr);
        check("setup_pwrite", m_pwrite, wr);
        check("setup_pstrb", m_pstrb, wr ? strb : 4'h0);
        if (wr) check("setup_pwdata", m_pwdata, wdata);
        check("setup_req_ready", req_ready, 0);
        // A slave response outside ACCESS must be ignored.
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        m_prdata  = 32'hBAD0_BAD0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            lat++;
            check("access_sel_en", {m_psel, m_penable}, 2'b11);
            check("access_paddr", m_paddr, addr);
            check("access_pstrb", m_pstrb, wr ? strb : 4'h0);
            m_pready  = (i == waits);
            m_pslverr = (i == waits) ? slverr : ~slverr;
            m_prdata  = (i == waits) ? prdata : $urandom;
        end
        @(negedge clk);
        lat++;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = $urandom;
        get_rsp(hold, w);
        check("latency", lat + w, waits + 3);
    endtask

    task automatic run_stuck();
        exp_t e;
        int   n;
        int   w;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
        e.err   = 1'b1;
        e.rdata = '0;
`else
        e.err   = 1'b0;
        e.rdata = 32'h5A5A_1234;
`endif
        exp_q.push_back(e);
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        n = 0;
        while (m_penable && n < 150) begin
            n++;
            @(negedge clk);
        end
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
        check("tmo_access_len", n, TMO);
`else
        check("stuck_access_len", n, 150);
        m_pready = 1'b1;
        m_prdata = 32'h5A5A_1234;
        @(negedge clk);
        m_pready = 1'b0;
`endif
        get_rsp(2, w);
    endtask

    task automatic run_reset_abort();
        issue(1'b1, 32'h20, 32'h1111_2222, 4'h3);
        @(negedge clk);
        check("pre_rst_penable", m_penable, 1);
        rstn = 1'b0;
        #1;
        check("rst_sel_en", {m_psel, m_penable}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", m_paddr, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_pready  = 1'b1;
            m_pslverr = 1'b1;
            @(negedge clk);
            check("post_rst_quiet", {rsp_valid, m_psel, m_penable}, 0);
        end
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_pstrb", m_pstrb, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_ctrl", {rsp_valid, rsp_err, m_psel, m_penable, m_pwrite}, 0);
        check("rst_out_data", {rsp_rdata, m_paddr}, 0);
        check("rst_out_wdata", {m_pwdata, m_pstrb}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);

        run_txn(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 2, 1'b0, 32'h01AA_BBCC, 1);
        run_txn(1'b0, 32'hC, 32'h0, 4'hF, 1, 1'b1, 32'hCAFE_F00D, 4);
        run_txn(1'b1, 32'h100, 32'h0BAD_F00D, 4'h5, 3, 1'b1, 32'h7777_7777, 2);
        run_stuck();
        run_reset_abort();
        run_txn(1'b0, 32'h40, 32'h0, 4'hA, 0, 1'b0, 32'h0F0F_0F0F, 0);
        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
